pcileech_rst_ctl: RTL

Reset and power-on sequencer for the ScreamerM2 top level. It is the stage directly upstream of the top-level consumers of system reset. It produces the synchronous active-high rst used by pcileech_com, pcileech_fifo and pcileech_pcie_a7, together with ft601_rst_n, the 64-bit tick counter and the power-on LED blink. It also synchronizes and debounces the asynchronous PCIe sideband inputs (pcie_perst_n, pcie_present) before they reach pcileech_fifo.

---
 rtl/pcileech_rst_ctl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pcileech_rst_ctl.sv
// pcileech_rst_ctl: reset and power-on sequencer for the ScreamerM2 top level.
// It produces the synchronous system reset, the FT601 reset, the free-running
// 64-bit tick counter and the power-on blink. It also synchronizes and
// debounces the asynchronous PCIe sideband pads.
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset (POR / MMCM locked)
//   sw_rst           one-cycle soft-reset request
//   pcie_perst_n_in  raw PERST# pad (asynchronous)
//   pcie_present_in  raw presence pad (asynchronous)
//   rst              synchronous active-high system reset (registered)
//   ft601_rst_n      FT601 reset, always the complement of rst
//   pcie_perst_n     synchronized, debounced PERST#
//   pcie_present     synchronized, debounced presence
//   perst_fall       one-cycle pulse on the pcie_perst_n 1->0 transition
//   tickcount64      free-running cycle counter
//   led_pwronblink   power-on blink
module pcileech_rst_ctl #(
    parameter int unsigned PARAM_RST_CYCLES = 64,
    parameter int unsigned PARAM_DEBOUNCE   = 16,
    parameter int unsigned PARAM_BLINK_BIT  = 24,
    parameter int unsigned PARAM_BLINK_END  = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sw_rst,
    input  logic        pcie_perst_n_in,
    input  logic        pcie_present_in,
    output logic        rst,
    output logic        ft601_rst_n,
    output logic        pcie_perst_n,
    output logic        pcie_present,
    output logic        perst_fall,
    output logic [63:0] tickcount64,
    output logic        led_pwronblink
);

    localparam int unsigned HOLD_W = 16;
    localparam int unsigned DB_W   = 8;
    localparam int unsigned NSB    = 2;   // index 0: PERST#, index 1: presence

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                rst_q, rst_d;
    logic                ft601_rst_n_q;
    logic [63:0]         tick_q;
    logic                blink_q, blink_d;

    (* ASYNC_REG = "TRUE" *) logic [NSB-1:0] sync0_q;
    (* ASYNC_REG = "TRUE" *) logic [NSB-1:0] sync1_q;
    logic [NSB-1:0]           db_q, db_d;
    logic [NSB-1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
    logic                     fall_q, fall_d;
    logic [NSB-1:0]           pad_c;

    assign pad_c = {pcie_present_in, pcie_perst_n_in};

    // Free-running tick counter; only rst_n clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + 64'd1;
        end
    end

    // Blink is live only while the upper tick bits are still zero.
    assign blink_d = tick_q[PARAM_BLINK_BIT] & ((tick_q >> PARAM_BLINK_END) == 64'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
        end
    end

    // Reset sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HOLD;
            hold_cnt_q    <= '0;
            rst_q         <= 1'b1;
            ft601_rst_n_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            rst_q         <= rst_d;
            ft601_rst_n_q <= ~rst_d;
        end
    end

    // Next state: sw_rst restarts the hold period and wins over terminal count.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rst_d      = rst_q;
        case (state_q)
            ST_HOLD: begin
                rst_d = 1'b1;
                if (sw_rst) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_W'(PARAM_RST_CYCLES - 1)) begin
                    state_d    = ST_RUN;
                    rst_d      = 1'b0;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                rst_d = 1'b0;
                if (sw_rst) begin
                    state_d    = ST_HOLD;
                    rst_d      = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_HOLD;
                rst_d      = 1'b1;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Sideband synchronizers and debounce registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q  <= '0;
            sync1_q  <= '0;
            db_q     <= '0;
            db_cnt_q <= '0;
            fall_q   <= 1'b0;
        end else begin
            sync0_q  <= pad_c;
            sync1_q  <= sync0_q;
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
            fall_q   <= fall_d;
        end
    end

    // Output follows s1 only after PARAM_DEBOUNCE consecutive differing cycles.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        for (int unsigned i = 0; i < NSB; i++) begin
            if (sync1_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_W'(PARAM_DEBOUNCE - 1)) begin
                    db_d[i] = sync1_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
        // Pulse is registered together with the debounced PERST# falling.
        fall_d = db_q[0] & ~db_d[0];
    end

    assign rst            = rst_q;
    assign ft601_rst_n    = ft601_rst_n_q;
    assign pcie_perst_n   = db_q[0];
    assign pcie_present   = db_q[1];
    assign perst_fall     = fall_q;
    assign tickcount64    = tick_q;
    assign led_pwronblink = blink_q;

endmodule
